// File: rtl/ppi_pkg.sv
// ============================================================================
//  Module      : ppi_pkg
//  Description : Shared types and helpers for the polyphase output commutator.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ppi_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ppi_state_t;

    // Phase counter width: clog2 with a floor of one bit
    function automatic int ppi_cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ppi_phase_counter.sv
// ============================================================================
//  Module      : ppi_phase_counter
//  Description : Saturating phase counter 0..N-1 with clear and terminal flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ppi_phase_counter
    import ppi_pkg::*;
#(
    parameter  int gp_nr_phases = 4,
    localparam int c_cnt_w      = ppi_cnt_width(gp_nr_phases)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_clr,
    input  logic               i_inc,
    output logic [c_cnt_w-1:0] o_count,
    output logic               o_last
);

    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(gp_nr_phases - 1);

    logic [c_cnt_w-1:0] r_count;
    logic               w_last;

    assign w_last = (r_count == c_last);

    // Holds at the terminal count so non-power-of-2 N never reaches illegal codes
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && !w_last) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_last  = w_last;

endmodule

`default_nettype wire

// File: rtl/ppi_output_commutator.sv
// ============================================================================
//  Module      : ppi_output_commutator
//  Description : Captures N polyphase branch samples and serialises them at
//                the output rate. Optional overrun flag: PPI_OUT_OVERRUN_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ppi_output_commutator
    import ppi_pkg::*;
#(
    parameter  int gp_data_width = 8,
    parameter  int gp_nr_phases  = 4,
    localparam int c_phase_w     = ppi_cnt_width(gp_nr_phases)
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic                                  i_ena,
    input  logic                                  i_load,
    input  logic [gp_nr_phases*gp_data_width-1:0] i_data,
    output logic [gp_data_width-1:0]              o_data,
    output logic                                  o_valid,
    output logic [c_phase_w-1:0]                  o_phase,
    output logic                                  o_burst_done,
    output logic                                  o_overrun
);

    ppi_state_t                              r_state;
    ppi_state_t                              w_state_next;
    logic [gp_nr_phases*gp_data_width-1:0]   r_buf;
    logic [gp_data_width-1:0]                r_data;
    logic                                    r_valid;
    logic                                    r_burst_done;
    logic [gp_data_width-1:0]                w_next_slice;
    logic [c_phase_w-1:0]                    w_phase;
    logic                                    w_last;
    logic                                    w_in_shift;
    logic                                    w_accept;
    logic                                    w_advance;
    logic                                    w_term;

    assign w_in_shift = (r_state == ST_SHIFT);
    // A new load is only taken when the previous burst is on its final phase
    assign w_accept   = i_ena && i_load && (!w_in_shift || w_last);
    assign w_advance  = i_ena && w_in_shift && !w_accept && !w_last;
    assign w_term     = i_ena && w_in_shift && w_last;

    ppi_phase_counter #(
        .gp_nr_phases (gp_nr_phases)
    ) u_phase_counter (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (w_accept),
        .i_inc   (w_advance),
        .o_count (w_phase),
        .o_last  (w_last)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_accept) begin
            w_state_next = ST_SHIFT;
        end else if (w_term) begin
            w_state_next = ST_IDLE;
        end
    end

    // Buffer slice for the phase following the current one
    always_comb begin
        w_next_slice = '0;
        for (int k = 1; k < gp_nr_phases; k++) begin
            if (w_phase == c_phase_w'(k - 1)) begin
                w_next_slice = r_buf[k*gp_data_width +: gp_data_width];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_buf        <= '0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_burst_done <= 1'b0;
        end else if (i_ena) begin
            if (w_accept) begin
                r_buf   <= i_data;
                r_data  <= i_data[gp_data_width-1:0];
                r_valid <= 1'b1;
            end else if (w_advance) begin
                r_data  <= w_next_slice;
            end else if (w_term) begin
                r_valid <= 1'b0;
            end
            if (w_term) begin
                r_burst_done <= 1'b1;
            end
        end
    end

`ifdef PPI_OUT_OVERRUN_EN
    logic r_overrun;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_overrun <= 1'b0;
        end else if (i_ena && i_load && w_in_shift && !w_last) begin
            r_overrun <= 1'b1;
        end
    end

    assign o_overrun = r_overrun;
`else
    assign o_overrun = 1'b0;
`endif

    assign o_data       = r_data;
    assign o_valid      = r_valid;
    assign o_phase      = w_phase;
    assign o_burst_done = r_burst_done;

endmodule

`default_nettype wire

// File: doc/ppi_output_commutator.md
# ppi_output_commutator

Output commutator for the polyphase interpolator (filt_ppi). It captures one low-rate sample from each of `gp_nr_phases` polyphase branches in a single strobe, then serializes them at the high (output) rate, one phase per enabled clock, with a valid flag and phase index. It is the output end of the polyphase path, opposite the input shift register/commutator that feeds the branch filters.

## Interface
- `gp_data_width`, 8, bit-width of each branch sample and of the serial output (signed, MSB:LSB).
- `gp_nr_phases`, 4, number of polyphase branches (interpolation factor); legal range ≥ 2.
- `i_clk`  in  1  rising-edge clock.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_ena`  in  1  synchronous active-high high-rate enable; no state changes when low.
- `i_load`  in  1  branch-sample strobe; sampled only when `i_ena`=1.
- `i_data`  in  gp_nr_phases*gp_data_width  concatenated branch samples; phase k = `i_data[(k+1)*gp_data_width-1 -: gp_data_width]`.
- `o_data`  out  gp_data_width  serialized sample, registered.
- `o_valid`  out  1  `o_data` holds a phase sample of the current burst.
- `o_phase`  out  clog2(gp_nr_phases)  index of the phase on `o_data`.
- `o_burst_done`  out  1  sticky; set once the first full burst is emitted.
- `o_overrun`  out  1  sticky; a load arrived mid-burst (see Configuration).

## Operation
- States: IDLE, SHIFT. Internal capture buffer `gp_nr_phases*gp_data_width` bits.
- Load accepted when `i_ena`=1, `i_load`=1, and (state IDLE, or state SHIFT with `o_phase`=N-1). On accept: buffer ← `i_data`; `o_data` ← phase-0 slice of `i_data`; `o_phase` ← 0; `o_valid` ← 1; state → SHIFT.
- SHIFT, `i_ena`=1, no accepted load:
  - `o_phase`<N-1: `o_phase`+1, `o_data` ← buffer[`o_phase`+1], `o_valid` stays 1.
  - `o_phase`=N-1: state → IDLE; `o_valid` ← 0; `o_data` and `o_phase` hold.
- `o_burst_done` ← 1 on any enabled edge in SHIFT with `o_phase`=N-1; it stays 1 until reset.
- A load in SHIFT with `o_phase`<N-1 is rejected. The buffer and the burst continue unchanged. It sets `o_overrun` when the feature is enabled.
- `i_ena`=0: all registers hold, `i_load` is ignored.
- Reset, including mid-burst, takes priority over everything: `o_data`=0, `o_valid`=0, `o_phase`=0, `o_burst_done`=0, `o_overrun`=0, buffer=0, state IDLE.
- Phase counter width = max(1, clog2(gp_nr_phases)). The counter never exceeds N-1; it does not wrap through illegal values for non-power-of-2 N.

## Timing
- Latency: accepted load at edge t → phase 0 on `o_data` after edge t; phase k after the k-th subsequent enabled edge.
- A burst is N enabled cycles of `o_valid`=1. Loads on every N-th enabled cycle (aligned to `o_phase`=N-1) give a gap-free output stream.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `PPI_OUT_OVERRUN_EN` defined: `o_overrun` sets on a rejected mid-burst load and is cleared only by `i_rst`.
- Not defined: the `o_overrun` register is not built and the output is tied to 0. Rejection behaviour is identical in both builds.

## Structure
- Shared package `ppi_pkg`: state encoding (IDLE/SHIFT), phase-counter width function (clog2 with minimum 1).
- Sub-module `ppi_phase_counter`: enable/clear/terminal-count counter 0..N-1 with a `last` flag. The FSM and buffer stay in the top.

## Test plan
- N=4, W=8, `i_ena`=1, one load of `i_data`=0x44332211 → `o_data` 0x11,0x22,0x33,0x44 on 4 consecutive cycles; `o_phase` 0..3; `o_valid`=1 for exactly 4 cycles; `o_burst_done` rises after the 0x44 cycle.
- Loads 0x44332211 then 0x88776655 issued at `o_phase`=3 → 8 contiguous valid outputs 0x11..0x88 with no gap.
- Load at `o_phase`=1 with 0xDDCCBBAA → ignored; output continues 0x33,0x44; `o_overrun`=1 with the macro, 0 without.
- `i_ena` toggling 1,0,0,1 during a burst → `o_data`, `o_phase`, `o_valid` hold through the low cycles; the sequence is unchanged.
- `i_rst` asserted at `o_phase`=2 → next cycle all outputs 0, state IDLE; a new load afterwards restarts at phase 0.
- N=3 (non-power-of-2), `i_data`=0x030201 → outputs 0x01,0x02,0x03; `o_phase` never exceeds 2.
